rx_deserializer: RTL and testbench

Receive-side front end of the serial memory interface: watches `rx_pins` for response frames and decodes the start-bit and status (sbs) cycle. It counts payload cycles and routes each response either to the instruction prefetcher or to the general load path. Routing uses an in-order queue of outstanding read requests pushed by the transmit side. It drives the `rx_*` strobes consumed directly by the prefetcher.

---
 rtl/rx_deserializer.sv | 124 ++++++++++++
 tb/tb_rx_deserializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
// Receive front end of the serial memory interface: decodes start/status cycles,
// counts payload cycles and steers each response to the prefetch or load path.
module rx_deserializer #(
  parameter int unsigned IO_BITS         = 2,
  parameter int unsigned PAYLOAD_CYCLES  = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CW = $clog2(PAYLOAD_CYCLES) + 1,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IO_BITS-1:0] rx_pins,
  input  logic               req_push,
  input  logic               req_prefetch,
  output logic               rx_started,
  output logic               rx_active,
  output logic [IO_BITS-1:0] rx_sbs,
  output logic               rx_sbs_valid,
  output logic [CW-1:0]      rx_counter,
  output logic               rx_data_valid,
  output logic               rx_done,
  output logic               rx_load_valid,
  output logic               rx_load_done,
  output logic [OW-1:0]      outstanding,
  output logic               rx_error
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(PAYLOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SBS, DATA} state_t;

  state_t                     state, state_next;
  logic [CW-1:0]              counter, counter_next;
  logic [MAX_OUTSTANDING-1:0] queue, queue_next;
  logic [OW-1:0]              count, count_next, count_after_pop;
  logic                       cur_prefetch, cur_prefetch_next;
  logic                       error_next;
  logic                       pop, push_ok;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and output decode
  always_comb begin
    state_next    = state;
    counter_next  = counter;
    rx_started    = 1'b0;
    rx_sbs_valid  = 1'b0;
    rx_sbs        = '0;
    rx_counter    = '0;
    rx_data_valid = 1'b0;
    rx_done       = 1'b0;
    rx_load_valid = 1'b0;
    rx_load_done  = 1'b0;
    rx_active     = (state != IDLE);
    case (state)
      IDLE: begin
        if (!rx_pins[0]) begin
          rx_started = !reset;
          state_next = SBS;
        end
      end
      SBS: begin
        rx_sbs_valid = 1'b1;
        rx_sbs       = rx_pins;
        counter_next = '0;
        state_next   = rx_pins[0] ? DATA : IDLE;
      end
      DATA: begin
        rx_counter    = counter;
        rx_data_valid = cur_prefetch;
        rx_load_valid = !cur_prefetch;
        if (counter == LAST_CYCLE) begin
          rx_done      = cur_prefetch;
          rx_load_done = !cur_prefetch;
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outstanding-request queue; head at bit 0, pop applied before push so a full queue accepts both
  always_comb begin
    pop             = (state == SBS) && (count != '0);
    count_after_pop = pop ? count - OW'(1) : count;
    queue_next      = pop ? (queue >> 1) : queue;
    push_ok         = req_push && (count_after_pop < OW'(MAX_OUTSTANDING));
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (push_ok && (count_after_pop == OW'(i))) queue_next[i] = req_prefetch;
    end
    count_next        = push_ok ? count_after_pop + OW'(1) : count_after_pop;
    cur_prefetch_next = (state == SBS) ? (pop && queue[0]) : cur_prefetch;
    error_next        = rx_error
                      || (req_push && !push_ok)
                      || ((state == SBS) && (count == '0))
                      || ((state == SBS) && pop && !rx_pins[0] && queue[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      queue        <= '0;
      count        <= '0;
      cur_prefetch <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      counter      <= counter_next;
      queue        <= queue_next;
      count        <= count_next;
      cur_prefetch <= cur_prefetch_next;
      rx_error     <= error_next;
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: inputs change on the falling edge and
// outputs are compared 1 time unit later.
module tb_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rx_pins = 2'b11;
  logic       req_push = 1'b0;
  logic       req_prefetch = 1'b0;
  logic       rx_started, rx_active, rx_sbs_valid;
  logic [1:0] rx_sbs;
  logic [3:0] rx_counter;
  logic       rx_data_valid, rx_done, rx_load_valid, rx_load_done;
  logic [1:0] outstanding;
  logic       rx_error;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rx_deserializer #(.IO_BITS(2), .PAYLOAD_CYCLES(8), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .rx_pins(rx_pins), .req_push(req_push),
    .req_prefetch(req_prefetch), .rx_started(rx_started), .rx_active(rx_active),
    .rx_sbs(rx_sbs), .rx_sbs_valid(rx_sbs_valid), .rx_counter(rx_counter),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done), .rx_load_valid(rx_load_valid),
    .rx_load_done(rx_load_done), .outstanding(outstanding), .rx_error(rx_error)
  );

  task automatic drive(input logic [1:0] pins, input logic push, input logic pf);
    @(negedge clk);
    rx_pins = pins; req_push = push; req_prefetch = pf;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; rx_pins = 2'b11; req_push = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  // Start cycle, status cycle and (if sbs[0]) the full payload with expected routing
  task automatic run_frame(input logic pf, input logic [1:0] sbs, input logic [1:0] exp_occ,
                           input string tag);
    logic [1:0] pins;
    drive(2'b00, 1'b0, 1'b0);
    vecs++; if (rx_started !== 1'b1) begin errs++; $display("FAIL %s started got %b exp 1", tag, rx_started); end
    vecs++; if (rx_active !== 1'b0) begin errs++; $display("FAIL %s active_at_start got %b exp 0", tag, rx_active); end
    drive(sbs, 1'b0, 1'b0);
    vecs++; if ({rx_sbs_valid, rx_sbs, rx_started, rx_active} !== {1'b1, sbs, 1'b0, 1'b1}) begin
      errs++; $display("FAIL %s sbs_cycle got v=%b sbs=%b st=%b act=%b exp v=1 sbs=%b st=0 act=1",
                       tag, rx_sbs_valid, rx_sbs, rx_started, rx_active, sbs);
    end
    if (sbs[0]) begin
      for (int i = 0; i < 8; i++) begin
        pins = 2'(3 - (i % 4));
        drive(pins, 1'b0, 1'b0);
        vecs++;
        if ({rx_counter, rx_data_valid, rx_load_valid, rx_done, rx_load_done, rx_sbs_valid, rx_started}
            !== {4'(i), pf, !pf, pf && (i == 7), !pf && (i == 7), 1'b0, 1'b0}) begin
          errs++;
          $display("FAIL %s payload[%0d] got cnt=%0d dv=%b lv=%b d=%b ld=%b sv=%b st=%b exp cnt=%0d dv=%b lv=%b d=%b ld=%b sv=0 st=0",
                   tag, i, rx_counter, rx_data_valid, rx_load_valid, rx_done, rx_load_done,
                   rx_sbs_valid, rx_started, i, pf, !pf, pf && (i == 7), !pf && (i == 7));
        end
        vecs++; if (outstanding !== exp_occ) begin errs++; $display("FAIL %s occ[%0d] got %0d exp %0d", tag, i, outstanding, exp_occ); end
      end
    end
  endtask

  task automatic test_reset();
    rx_pins = 2'b00; #1;
    vecs++; if (rx_started !== 1'b0) begin errs++; $display("FAIL reset_started got %b exp 0", rx_started); end
    vecs++; if ({rx_active, rx_sbs_valid, rx_counter, rx_data_valid, rx_load_valid, outstanding, rx_error} !== '0) begin
      errs++; $display("FAIL reset_outputs got act=%b sv=%b cnt=%0d dv=%b lv=%b occ=%0d err=%b exp all 0",
                       rx_active, rx_sbs_valid, rx_counter, rx_data_valid, rx_load_valid, outstanding, rx_error);
    end
    @(negedge clk); rx_pins = 2'b11; reset = 1'b0;
  endtask

  task automatic test_single_prefetch();
    drive(2'b11, 1'b1, 1'b1);
    run_frame(1'b1, 2'b01, 2'd0, "single_pf");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({rx_active, rx_error, outstanding} !== 4'b0000) begin
      errs++; $display("FAIL single_pf_end got act=%b err=%b occ=%0d exp 0 0 0", rx_active, rx_error, outstanding);
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b1);
    run_frame(1'b0, 2'b01, 2'd1, "mixed_load");
    run_frame(1'b1, 2'b01, 2'd0, "mixed_pf");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({rx_active, rx_error} !== 2'b00) begin errs++; $display("FAIL mixed_end got act=%b err=%b exp 0 0", rx_active, rx_error); end
  endtask

  task automatic test_ack_only();
    drive(2'b11, 1'b1, 1'b0);
    run_frame(1'b0, 2'b00, 2'd0, "ack");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({rx_active, rx_data_valid, rx_load_valid, outstanding, rx_error} !== 6'b0) begin
      errs++; $display("FAIL ack_end got act=%b dv=%b lv=%b occ=%0d err=%b exp all 0",
                       rx_active, rx_data_valid, rx_load_valid, outstanding, rx_error);
    end
  endtask

  task automatic test_err_empty();
    pulse_reset();
    run_frame(1'b0, 2'b01, 2'd0, "err_empty");
    vecs++; if (rx_error !== 1'b1) begin errs++; $display("FAIL err_empty_flag got %b exp 1", rx_error); end
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if (rx_error !== 1'b1) begin errs++; $display("FAIL err_empty_sticky got %b exp 1", rx_error); end
  endtask

  task automatic test_err_full();
    pulse_reset();
    for (int i = 0; i < 3; i++) drive(2'b11, 1'b1, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({outstanding, rx_error} !== {2'd2, 1'b1}) begin
      errs++; $display("FAIL err_full got occ=%0d err=%b exp occ=2 err=1", outstanding, rx_error);
    end
  endtask

  task automatic test_err_ack_pf();
    pulse_reset();
    drive(2'b11, 1'b1, 1'b1);
    run_frame(1'b1, 2'b00, 2'd0, "err_ack_pf");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({outstanding, rx_error, rx_active} !== {2'd0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL err_ack_pf got occ=%0d err=%b act=%b exp occ=0 err=1 act=0", outstanding, rx_error, rx_active);
    end
  endtask

  task automatic test_full_push_pop();
    pulse_reset();
    drive(2'b11, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    vecs++; if ({rx_started, outstanding} !== {1'b1, 2'd2}) begin
      errs++; $display("FAIL fpp_start got st=%b occ=%0d exp st=1 occ=2", rx_started, outstanding);
    end
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({outstanding, rx_error, rx_load_valid, rx_data_valid} !== {2'd2, 1'b0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL fpp_after_pop got occ=%0d err=%b lv=%b dv=%b exp occ=2 err=0 lv=1 dv=0",
                       outstanding, rx_error, rx_load_valid, rx_data_valid);
    end
    for (int i = 1; i < 8; i++) drive(2'b11, 1'b0, 1'b0);
    run_frame(1'b1, 2'b01, 2'd1, "fpp_next");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if (rx_error !== 1'b0) begin errs++; $display("FAIL fpp_err got %b exp 0", rx_error); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_reset();
    drive(2'b11, 1'b1, 1'b1);
    drive(2'b00, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(2'(3 - (i % 4)), 1'b0, 1'b0);
    vecs++; if ({rx_counter, rx_data_valid} !== {4'd4, 1'b1}) begin
      errs++; $display("FAIL mid_before got cnt=%0d dv=%b exp cnt=4 dv=1", rx_counter, rx_data_valid);
    end
    reset = 1'b1; rx_pins = 2'b00; #1;
    vecs++; if ({rx_started, rx_active, rx_counter, rx_data_valid, rx_done, outstanding, rx_error} !== '0) begin
      errs++; $display("FAIL mid_reset got st=%b act=%b cnt=%0d dv=%b d=%b occ=%0d err=%b exp all 0",
                       rx_started, rx_active, rx_counter, rx_data_valid, rx_done, outstanding, rx_error);
    end
    @(negedge clk); reset = 1'b0; rx_pins = 2'b11;
    drive(2'b11, 1'b1, 1'b1);
    run_frame(1'b1, 2'b01, 2'd0, "post_reset");
    drive(2'b11, 1'b0, 1'b0);
    vecs++; if ({rx_active, rx_error} !== 2'b00) begin errs++; $display("FAIL post_reset_end got act=%b err=%b exp 0 0", rx_active, rx_error); end
  endtask

  initial begin
    test_reset();
    test_single_prefetch();
    test_back_to_back();
    test_ack_only();
    test_err_empty();
    test_err_full();
    test_err_ack_pf();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
